// File: rtl/wb_regfile.sv
// Write-back stage and 32-entry register file: selects write data/destination, commits on
// the rising edge, and serves two bypassed read ports. Define WB_DEBUG_PORT_EN for debug ports.
module wb_regfile #(
  parameter int             DW      = 32,
  parameter logic [DW-1:0]  SP_INIT = 'h3FC,
  parameter logic [4:0]     RA_REG  = 5'd31,
  parameter logic [4:0]     XP_REG  = 5'd26
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] wb_in_a,
  input  logic [DW-1:0] wb_in_b,
  input  logic [DW-1:0] wb_pc,
  input  logic [1:0]    wb_memtoreg,
  input  logic [1:0]    wb_regdst,
  input  logic [4:0]    wb_wrreg,
  input  logic [4:0]    wb_rd,
  input  logic          wb_regwr,
  input  logic [4:0]    rd_addr1,
  input  logic [4:0]    rd_addr2,
  output logic [DW-1:0] rd_data1,
  output logic [DW-1:0] rd_data2,
  output logic [4:0]    wb_waddr,
  output logic [DW-1:0] wb_wdata,
  output logic          wb_wvalid
`ifdef WB_DEBUG_PORT_EN
  ,
  input  logic [4:0]    dbg_addr,
  output logic [DW-1:0] dbg_data,
  output logic [31:0]   dbg_wcount
`endif
);

  localparam int NREGS = 32;
  localparam int SP_IDX = 29;

  logic [DW-1:0] regs_q [NREGS];
  logic [DW-1:0] regs_d [NREGS];
  logic [DW-1:0] wdata_c;
  logic [4:0]    waddr_c;
  logic          commit_c;
  logic [4:0]    waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          wvalid_q, wvalid_d;

  // NOTE: always_comb uses blocking '=' with every output given a default first, so no latch is inferred.
  always_comb begin
    wdata_c = wb_in_a;
    unique case (wb_memtoreg)
      2'b00: wdata_c = wb_in_a;
      2'b01: wdata_c = wb_in_b;
      2'b10: wdata_c = wb_pc + DW'(4);
      2'b11: wdata_c = wb_pc;
    endcase

    waddr_c = wb_wrreg;
    unique case (wb_regdst)
      2'b00: waddr_c = wb_wrreg;
      2'b01: waddr_c = wb_rd;
      2'b10: waddr_c = RA_REG;
      2'b11: waddr_c = XP_REG;
    endcase

    // $0 is hard-wired: a write to it is dropped and never flagged as valid.
    commit_c = wb_regwr && (waddr_c != 5'd0);

    regs_d = regs_q;
    if (commit_c) regs_d[waddr_c] = wdata_c;

    waddr_d  = waddr_c;
    wdata_d  = wdata_c;
    wvalid_d = commit_c;
  end

  // NOTE: the array is reset explicitly because software relies on zeroed registers and a preset $sp.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= (i == SP_IDX) ? SP_INIT : '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      wvalid_q <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      wvalid_q <= wvalid_d;
    end
  end

  // Write-through bypass lets ID see the value WB is committing this cycle.
  assign rd_data1 = (rd_addr1 == 5'd0)                    ? '0      :
                    (wb_regwr && (waddr_c == rd_addr1))   ? wdata_c : regs_q[rd_addr1];
  assign rd_data2 = (rd_addr2 == 5'd0)                    ? '0      :
                    (wb_regwr && (waddr_c == rd_addr2))   ? wdata_c : regs_q[rd_addr2];

  assign wb_waddr  = waddr_q;
  assign wb_wdata  = wdata_q;
  assign wb_wvalid = wvalid_q;

`ifdef WB_DEBUG_PORT_EN
  logic [31:0] wcount_q, wcount_d;

  always_comb begin
    wcount_d = wcount_q + {31'd0, commit_c};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wcount_q <= '0;
    else       wcount_q <= wcount_d;
  end

  // Raw array view: no bypass, so it shows only committed state.
  assign dbg_data   = (dbg_addr == 5'd0) ? '0 : regs_q[dbg_addr];
  assign dbg_wcount = wcount_q;
`endif

endmodule
